// File: rtl/apb_master_ctrl.sv
// apb_master_ctrl: single-command APB initiator for three peripherals (IDLE/SETUP/ACCESS/RESP).
// Optional build macro APB_TIMEOUT_EN bounds the number of ACCESS cycles spent waiting on pready.
module apb_master_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              Hclk,
  input  logic              Hresetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [2:0]        pselx,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        pselx_q, pselx_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic [2:0]        sel_s;
  logic              timeout_s;

  // Top six address bits pick the peripheral; anything else is unmapped.
  function automatic logic [2:0] decode_sel(input logic [5:0] top_bits);
    logic [2:0] sel;
    case (top_bits)
      6'b100000: sel = 3'b001;
      6'b100001: sel = 3'b010;
      6'b100010: sel = 3'b100;
      default:   sel = 3'b000;
    endcase
    return sel;
  endfunction

  assign sel_s     = decode_sel(cmd_addr[ADDR_W-1 -: 6]);
  assign cmd_ready = (state_q == ST_IDLE);

`ifdef APB_TIMEOUT_EN
  localparam int               CNT_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  assign timeout_s = (state_q == ST_ACCESS) && !pready && (wait_cnt_q == CNT_LAST);

  // Wait counter: cleared in SETUP so it starts at zero on ACCESS entry.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_q == ST_SETUP) begin
      wait_cnt_d = {CNT_W{1'b0}};
    end else if ((state_q == ST_ACCESS) && !pready && !timeout_s) begin
      wait_cnt_d = wait_cnt_q + CNT_W'(1'b1);
    end else begin
      wait_cnt_d = wait_cnt_q;
    end
  end

  // Wait counter register.
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      wait_cnt_q <= {CNT_W{1'b0}};
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end
`else
  logic [31:0] unused_timeout_cfg_s;

  assign timeout_s            = 1'b0;
  assign unused_timeout_cfg_s = 32'(TIMEOUT_CYC);
`endif

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (sel_s != 3'b000) begin
            state_d = ST_SETUP;
          end else begin
            state_d = ST_RESP;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (pready || timeout_s) begin
          state_d = ST_RESP;
        end else begin
          state_d = ST_ACCESS;
        end
      end
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered APB and response outputs.
  always_comb begin
    pselx_d     = pselx_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (sel_s != 3'b000) begin
            pselx_d   = sel_s;
            penable_d = 1'b0;
            pwrite_d  = cmd_write;
            paddr_d   = cmd_addr;
            if (cmd_write) begin
              pwdata_d = cmd_wdata;
            end else begin
              pwdata_d = pwdata_q;
            end
          end else begin
            // Unmapped: answer with an error, leave the APB bus untouched.
            rsp_valid_d = 1'b1;
            rsp_rdata_d = {DATA_W{1'b0}};
            rsp_err_d   = 1'b1;
          end
        end else begin
          rsp_valid_d = 1'b0;
        end
      end
      ST_SETUP: begin
        penable_d = 1'b1;
      end
      ST_ACCESS: begin
        if (pready) begin
          pselx_d     = 3'b000;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = pslverr;
          if (pwrite_q || pslverr) begin
            rsp_rdata_d = {DATA_W{1'b0}};
          end else begin
            rsp_rdata_d = prdata;
          end
        end else if (timeout_s) begin
          pselx_d     = 3'b000;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = {DATA_W{1'b0}};
        end else begin
          penable_d = 1'b1;
        end
      end
      ST_RESP: begin
        rsp_valid_d = 1'b0;
      end
      default: begin
        pselx_d   = 3'b000;
        penable_d = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      state_q     <= ST_IDLE;
      pselx_q     <= 3'b000;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= {ADDR_W{1'b0}};
      pwdata_q    <= {DATA_W{1'b0}};
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= {DATA_W{1'b0}};
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pselx_q     <= pselx_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign pselx     = pselx_q;
  assign penable   = penable_q;
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
